// File: rtl/uart_tx_frame.sv
// Parametrised UART serialiser with a one-entry holding register on a valid/ready input.
// Frames are start, DATA_BITS data bits sent LSB first, optional parity, then STOP_BITS stop bits.
module uart_tx_frame #(
  parameter int CPB       = 1250,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_Tx,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [3:0]           o_bit_index
);

  if (CPB < 2) begin : g_bad_cpb
    $error("uart_tx_frame: CPB must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  localparam int              CNT_W     = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [3:0]      PAR_IDX   = 4'(DATA_BITS + 1);
  localparam logic [3:0]      STOP_IDX  = 4'(DATA_BITS + 1 + ((PARITY != 0) ? 1 : 0));

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [3:0]           bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [DATA_BITS-1:0] hold;
  logic                 full;
  logic                 par_bit, par_n;
  logic                 tx_n;
  logic [3:0]           idx_n;
  logic                 bit_end, last_data, last_stop;
  logic                 accept, consume;

  assign bit_end   = (cnt == CNT_LAST);
  assign last_data = (bit_cnt == 4'(DATA_BITS - 1));
  assign last_stop = (bit_cnt == 4'(STOP_BITS - 1));
  assign accept    = i_valid && !full;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n   = state;
    cnt_n     = (state == S_IDLE || bit_end) ? '0 : cnt + CNT_W'(1);
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_n     = par_bit;
    consume   = 1'b0;

    unique case (state)
      S_IDLE:   if (full) consume = 1'b1;
      S_START:  if (bit_end) begin
                  state_n   = S_DATA;
                  bit_cnt_n = '0;
                end
      S_DATA:   if (bit_end) begin
                  shift_n = shift >> 1;
                  if (last_data) begin
                    state_n   = (PARITY != 0) ? S_PARITY : S_STOP;
                    bit_cnt_n = '0;
                  end else begin
                    bit_cnt_n = bit_cnt + 4'd1;
                  end
                end
      S_PARITY: if (bit_end) begin
                  state_n   = S_STOP;
                  bit_cnt_n = '0;
                end
      S_STOP:   if (bit_end) begin
                  if (!last_stop) bit_cnt_n = bit_cnt + 4'd1;
                  else if (full)  consume   = 1'b1;
                  else            state_n   = S_IDLE;
                end
      default:  state_n = S_IDLE;
    endcase

    // Taking the held word starts the next frame immediately, with no idle gap.
    if (consume) begin
      state_n   = S_START;
      cnt_n     = '0;
      bit_cnt_n = '0;
      shift_n   = hold;
      par_n     = (^hold) ^ (PARITY == 1);
    end

    // Line level and bit index are registered from the next state so they stay aligned.
    tx_n  = 1'b1;
    idx_n = '0;
    unique case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   begin tx_n = shift_n[0]; idx_n = 4'd1 + bit_cnt_n; end
      S_PARITY: begin tx_n = par_n;      idx_n = PAR_IDX;          end
      S_STOP:   idx_n = STOP_IDX + bit_cnt_n;
      default:  ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      full        <= 1'b0;
      o_Tx        <= 1'b1;
      o_bit_index <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_cnt     <= bit_cnt_n;
      o_Tx        <= tx_n;
      o_bit_index <= idx_n;
      if (consume)     full <= 1'b0;
      else if (accept) full <= 1'b1;
    end
  end

  // NOTE: the data path carries no reset; its contents only matter once the full flag or FSM qualifies them.
  always_ff @(posedge clk) begin
    shift   <= shift_n;
    par_bit <= par_n;
    if (accept) hold <= i_data;
  end

  assign o_ready = !full;
  assign o_busy  = (state != S_IDLE);
  assign o_done  = (state == S_STOP) && bit_end && last_stop;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: four parameterisations share one driver and one frame monitor.
// Expected words are queued on accept; the monitor rebuilds each frame's waveform and compares it.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       nRST;
  logic [8:0] drv_data;
  logic       drv_valid;
  logic [1:0] sel;
  logic       mon_en;

  logic       tx_w [4];
  logic       rdy_w [4];
  logic       busy_w [4];
  logic       done_w [4];
  logic [3:0] idx_w [4];

  logic       obs_tx, obs_ready, obs_busy, obs_done;
  logic [3:0] obs_idx;

  int cfg_cpb [4] = '{4, 4, 4, 3};
  int cfg_db  [4] = '{8, 8, 8, 9};
  int cfg_par [4] = '{0, 2, 1, 0};
  int cfg_sb  [4] = '{1, 1, 1, 2};

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         frames_done = 0;
  logic [8:0] sb_q [$];
  int         start_cyc [$];

  assign obs_tx    = tx_w[sel];
  assign obs_ready = rdy_w[sel];
  assign obs_busy  = busy_w[sel];
  assign obs_done  = done_w[sel];
  assign obs_idx   = idx_w[sel];

  uart_tx_frame #(.CPB(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_8n1 (
    .clk(clk), .nRST(nRST), .i_data(drv_data[7:0]), .i_valid(drv_valid && sel == 2'd0),
    .o_ready(rdy_w[0]), .o_Tx(tx_w[0]), .o_busy(busy_w[0]), .o_done(done_w[0]), .o_bit_index(idx_w[0]));

  uart_tx_frame #(.CPB(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_8e1 (
    .clk(clk), .nRST(nRST), .i_data(drv_data[7:0]), .i_valid(drv_valid && sel == 2'd1),
    .o_ready(rdy_w[1]), .o_Tx(tx_w[1]), .o_busy(busy_w[1]), .o_done(done_w[1]), .o_bit_index(idx_w[1]));

  uart_tx_frame #(.CPB(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_8o1 (
    .clk(clk), .nRST(nRST), .i_data(drv_data[7:0]), .i_valid(drv_valid && sel == 2'd2),
    .o_ready(rdy_w[2]), .o_Tx(tx_w[2]), .o_busy(busy_w[2]), .o_done(done_w[2]), .o_bit_index(idx_w[2]));

  uart_tx_frame #(.CPB(3), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2)) dut_9n2 (
    .clk(clk), .nRST(nRST), .i_data(drv_data), .i_valid(drv_valid && sel == 2'd3),
    .o_ready(rdy_w[3]), .o_Tx(tx_w[3]), .o_busy(busy_w[3]), .o_done(done_w[3]), .o_bit_index(idx_w[3]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the accept edge.
  task automatic send(input logic [8:0] w, input bit keep_valid, output int acc_cyc);
    int n = 0;
    logic [8:0] mask;
    mask      = (9'd1 << cfg_db[sel]) - 9'd1;
    drv_data  = w;
    drv_valid = 1'b1;
    while (!obs_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send_ready_timeout", {63'd0, obs_ready}, 64'd1);
    if (mon_en) sb_q.push_back(w & mask);
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    if (!keep_valid) begin
      drv_valid = 1'b0;
      drv_data  = 9'($urandom);
    end
  endtask

  task automatic wait_frames(input int n);
    int k = 0;
    while (frames_done < n && k < 600) begin
      @(negedge clk);
      k++;
    end
    check("frame_count", frames_done, n);
  endtask

  int          m_cpb, m_db, m_len, m_b;
  logic        m_hp, m_par;
  logic [8:0]  m_w;
  logic [63:0] m_tx_got, m_tx_exp, m_done_got, m_done_exp, m_busy_got, m_busy_exp;
  logic [63:0] m_idx_first, m_idx_last, m_idx_exp;

  // Frame monitor: a low line while idle marks a start bit; capture exactly one frame length.
  always begin : monitor
    @(negedge clk);
    if (mon_en && nRST === 1'b1 && obs_tx === 1'b0) begin
      m_cpb = cfg_cpb[sel];
      m_db  = cfg_db[sel];
      m_hp  = (cfg_par[sel] != 0);
      m_len = (1 + m_db + int'(m_hp) + cfg_sb[sel]) * m_cpb;
      start_cyc.push_back(cyc);
      check("sb_pending", {63'd0, sb_q.size() != 0}, 64'd1);
      m_w   = (sb_q.size() != 0) ? sb_q.pop_front() : 9'd0;
      m_par = (cfg_par[sel] == 1) ? ~^m_w : ^m_w;
      m_tx_got = '0; m_tx_exp = '0; m_done_got = '0; m_done_exp = '0; m_busy_got = '0;
      m_idx_first = '0; m_idx_last = '0; m_idx_exp = '0;
      m_busy_exp = (64'd1 << m_len) - 64'd1;
      for (int c = 0; c < m_len; c++) begin
        if (c > 0) @(negedge clk);
        m_b = c / m_cpb;
        if (m_b == 0)                 m_tx_exp[c] = 1'b0;
        else if (m_b <= m_db)         m_tx_exp[c] = m_w[m_b-1];
        else if (m_hp && m_b == m_db + 1) m_tx_exp[c] = m_par;
        else                          m_tx_exp[c] = 1'b1;
        m_done_exp[c] = (c == m_len - 1);
        m_tx_got[c]   = obs_tx;
        m_done_got[c] = obs_done;
        m_busy_got[c] = obs_busy;
        m_idx_exp[m_b*4 +: 4] = 4'(m_b);
        if (c % m_cpb == 0)         m_idx_first[m_b*4 +: 4] = obs_idx;
        if (c % m_cpb == m_cpb - 1) m_idx_last[m_b*4 +: 4]  = obs_idx;
      end
      check("frame_tx", m_tx_got, m_tx_exp);
      check("frame_done", m_done_got, m_done_exp);
      check("frame_busy", m_busy_got, m_busy_exp);
      check("frame_idx_first", m_idx_first, m_idx_exp);
      check("frame_idx_last", m_idx_last, m_idx_exp);
      frames_done++;
    end
  end

  initial begin
    int acc0, acc1, n;
    logic seen;

    nRST = 1'b0; drv_valid = 1'b1; drv_data = 9'h0A5; sel = 2'd0; mon_en = 1'b1;

    // Reset held with i_valid high: line idle, ready, no activity.
    repeat (5) begin
      @(negedge clk);
      check("reset_outputs", {60'd0, obs_tx, obs_ready, obs_busy, obs_done}, 64'hC);
      check("reset_idx", obs_idx, 0);
    end
    drv_valid = 1'b0;
    nRST = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen |= obs_busy;
    end
    check("idle_after_reset", {63'd0, seen}, 64'd0);

    // 8N1 0xA5 with latency and ready-pulse checks.
    send(9'h0A5, 1'b0, acc0);
    check("lat_ready_low", {62'd0, obs_ready, obs_tx}, 64'h1);
    @(negedge clk);
    check("lat_start", {62'd0, obs_ready, obs_tx}, 64'h2);
    wait_frames(1);
    @(negedge clk);
    check("busy_after_frame", {63'd0, obs_busy}, 64'd0);

    // Parity: even then odd, 0x07 has three ones.
    sel = 2'd1;
    @(negedge clk);
    send(9'h007, 1'b0, acc0);
    wait_frames(2);
    sel = 2'd2;
    @(negedge clk);
    send(9'h007, 1'b0, acc0);
    wait_frames(3);

    // Back-to-back with i_valid held.
    sel = 2'd0;
    @(negedge clk);
    start_cyc.delete();
    send(9'h055, 1'b1, acc0);
    send(9'h00F, 1'b0, acc1);
    check("b2b_accept_gap", acc1 - acc0, 2);
    n = 0;
    while (!obs_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("b2b_ready_low", n, 39);
    wait_frames(5);
    check("b2b_starts", start_cyc.size(), 2);
    if (start_cyc.size() == 2) check("b2b_gap", start_cyc[1] - start_cyc[0], 40);

    // Abort mid-frame with a second word held.
    @(negedge clk);
    mon_en = 1'b0;
    send(9'h0A5, 1'b1, acc0);
    send(9'h03C, 1'b0, acc1);
    n = 0;
    seen = 1'b0;
    while (obs_idx != 4'd4 && n < 200) begin
      seen |= obs_done;
      @(negedge clk);
      n++;
    end
    check("abort_reach_bit3", obs_idx, 4);
    nRST = 1'b0;
    @(negedge clk);
    check("abort_outputs", {60'd0, obs_tx, obs_ready, obs_busy, obs_done}, 64'hC);
    nRST = 1'b1;
    repeat (60) begin
      @(negedge clk);
      seen |= obs_done | obs_busy;
    end
    check("abort_no_activity", {63'd0, seen}, 64'd0);
    mon_en = 1'b1;
    send(9'h03C, 1'b0, acc0);
    wait_frames(6);

    // 9N2, CPB=3, all ones.
    sel = 2'd3;
    @(negedge clk);
    send(9'h1FF, 1'b0, acc0);
    wait_frames(7);

    repeat (5) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART serialiser, successor to the fixed 9600-8N1 transmitter.
- Data width, parity mode, stop-bit count and clocks-per-bit are set by parameters.
- Upstream uses a valid/ready handshake backed by a one-entry holding register, so back-to-back frames go out with no idle gap.
- Sits between a byte/word source (FIFO or control FSM) and the board TX pin.

Parameters:
CPB, 1250, clocks per bit (12 MHz / 9600 baud); legal range >= 2
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame; legal range 1..2

Ports:
clk  input  1  system clock, 12 MHz
nRST  input  1  synchronous active-low reset
i_data  input  DATA_BITS  word to transmit; sampled only on accept
i_valid  input  1  upstream has a word on i_data
o_ready  output  1  holding register empty; accept occurs when i_valid && o_ready at a clk rising edge
o_Tx  output  1  serial line, idle high, registered
o_busy  output  1  high from first start-bit cycle through last stop-bit cycle
o_done  output  1  one-cycle pulse at the end of each frame's last stop bit
o_bit_index  output  4  bit currently on the line: 0 = start, 1..DATA_BITS = data, then parity (if enabled), then stop(s)

Behaviour:
- Reset (nRST low at an edge):
  - o_Tx=1, o_ready=1, o_busy=0, o_done=0, o_bit_index=0.
  - State IDLE, holding register empty, baud counter 0.
  - i_valid is ignored while nRST is low.
- Reset mid-frame: on the next edge o_Tx returns to 1 and the frame is aborted. The held word and the in-flight word are discarded, and no o_done is issued.
- Baud counter:
  - Width is clog2(CPB).
  - Counts 0..CPB-1 while the state is not IDLE and wraps to 0; it is held at 0 in IDLE.
  - Every bit lasts exactly CPB cycles.
- Holding register:
  - The accept edge stores i_data and sets the full flag; o_ready = !full.
  - The FSM consumes the word (clearing full) when it is in IDLE, or on the last cycle of the final stop bit.
  - An accept and a consume can never occur on the same edge, because o_ready=0 while full.
- FSM states and transitions:
  - IDLE: o_Tx=1. If the register is full, load the shift register, clear full, go to START.
  - START: o_Tx=0 for CPB cycles, then go to DATA.
  - DATA: DATA_BITS bits, LSB first, CPB cycles each. Then go to PARITY if PARITY != 0, else STOP.
  - PARITY: even parity bit = XOR of the data bits; odd = its inverse. CPB cycles, then STOP.
  - STOP: o_Tx=1 for STOP_BITS*CPB cycles. On the last cycle, pulse o_done; go to START if the register is full (no idle gap), else IDLE.
- Latency: accept at edge k -> o_Tx falls at edge k+1, and o_ready is low for exactly one cycle (k to k+1).
- Frame length: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CPB cycles.
- With i_valid held continuously, a second word is accepted at edge k+2. o_ready then stays low until that word is consumed at the end of the current frame.
- Upper or unused i_data bits never appear on the line. Changes to i_data outside the accept edge have no effect.
- o_bit_index is registered and aligned with o_Tx.
- Illegal parameter values (CPB < 2, DATA_BITS outside 5..9, PARITY > 2, STOP_BITS outside 1..2) cause an elaboration-time error.

Test Plan:
1. Reset: nRST=0 for 5 cycles with i_valid=1 -> o_Tx=1, o_ready=1, o_busy=0, o_done=0 throughout; no frame follows release unless i_valid is still high.
2. 8N1, CPB=4, send 0xA5:
   - o_Tx = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles.
   - Frame = 40 cycles; o_done pulses once on cycle 40; o_busy high for exactly 40 cycles.
3. Parity, CPB=4, DATA_BITS=8, send 0x07:
   - PARITY=2 (even) -> parity bit 1 (4 cycles).
   - PARITY=1 (odd) -> parity bit 0.
   - Frame = 44 cycles.
4. Back-to-back, 8N1, CPB=4: i_valid held with 0x55 then 0x0F.
   - Second word accepted 2 edges after the first accept.
   - o_ready low until the first frame's final stop cycle.
   - Start bit of 0x0F immediately follows the stop bit of 0x55 (zero idle cycles); two o_done pulses 40 cycles apart.
5. Abort: assert nRST during data bit 3 of 0xA5 with 0x3C held -> o_Tx=1 next cycle, o_ready=1, no o_done. A later send of 0x3C produces a clean 40-cycle frame.
6. DATA_BITS=9, STOP_BITS=2, PARITY=0, CPB=3, send 9'h1FF -> start 0 for 3 cycles, nine 1-bits, 6 stop cycles. Frame = 36 cycles; o_bit_index steps 0..11.
